// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline WB result always wins, mult/div results queue
// in a FIFO and drain on idle cycles. Optional md->rf bypass via the WB_ARB_BYPASS_EN macro.
module wb_port_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_wr_en,
  input  logic [AW-1:0] pipe_wr_addr,
  input  logic [DW-1:0] pipe_wr_data,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [AW-1:0] md_wr_addr,
  input  logic [DW-1:0] md_wr_data,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_wr_data,
  output logic          stall_req,
  output logic          md_pending,
  output logic          proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WAIT);
  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] STARVE = 1'b1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [0:0]    state;
  logic [CW-1:0] wait_cnt;

  logic pipe_take;
  logic md_take;
  logic bypass_take;
  logic push;
  logic pop;
  logic blocked;

  assign md_ready   = (count != (PW+1)'(DEPTH));
  assign md_pending = (count != '0);
  assign stall_req  = (state == STARVE);

  always_comb begin
    pipe_take = pipe_wr_en && (pipe_wr_addr != '0);
    // r0 writes complete the handshake but are otherwise discarded
    md_take   = md_valid && md_ready && (md_wr_addr != '0);
    pop       = !pipe_take && (count != '0);
`ifdef WB_ARB_BYPASS_EN
    bypass_take = !pipe_take && (count == '0) && md_take;
`else
    bypass_take = 1'b0;
`endif
    push      = md_take && !bypass_take;
    blocked   = (count != '0) && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= md_wr_addr;
      data_mem[wr_ptr] <= md_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else if (pipe_take) begin
      rf_wr_en   <= 1'b1;
      rf_wr_addr <= pipe_wr_addr;
      rf_wr_data <= pipe_wr_data;
    end else if (pop) begin
      rf_wr_en   <= 1'b1;
      rf_wr_addr <= addr_mem[rd_ptr];
      rf_wr_data <= data_mem[rd_ptr];
    end else if (bypass_take) begin
      rf_wr_en   <= 1'b1;
      rf_wr_addr <= md_wr_addr;
      rf_wr_data <= md_wr_data;
    end else begin
      rf_wr_en   <= 1'b0;
    end
  end

  // Starvation timer: one bubble after MAX_WAIT blocked cycles of a non-empty head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      wait_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (!blocked) begin
            wait_cnt <= '0;
          end else if (wait_cnt == CW'(MAX_WAIT-1)) begin
            state    <= STARVE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          if (pipe_wr_en) proto_err <= 1'b1;
          state    <= ARB;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a queue-based reference model checked every cycle.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;
  localparam int MAX_WAIT = 8;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pipe_wr_en = 1'b0;
  logic [AW-1:0] pipe_wr_addr = '0;
  logic [DW-1:0] pipe_wr_data = '0;
  logic          md_valid = 1'b0;
  logic          md_ready;
  logic [AW-1:0] md_wr_addr = '0;
  logic [DW-1:0] md_wr_data = '0;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic          stall_req;
  logic          md_pending;
  logic          proto_err;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  wb_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_wr_addr(md_wr_addr), .md_wr_data(md_wr_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .stall_req(stall_req), .md_pending(md_pending), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending results as a queue, starvation as a counted run of blocked cycles
  logic [AW-1:0] qa[$];
  logic [DW-1:0] qd[$];
  int            m_blocked_run;
  bit            m_stall, m_err, m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete(); qd.delete();
      m_blocked_run = 0; m_stall = 0; m_err = 0; m_en = 0; m_addr = '0; m_data = '0;
    end else begin
      bit pipe_go, accept, byp, had;
      pipe_go = pipe_wr_en && pipe_wr_addr != 0;
      had     = qa.size() > 0;
      accept  = md_valid && qa.size() < DEPTH;
      byp     = BYP && !pipe_go && !had && accept && md_wr_addr != 0;
      if (m_stall && pipe_wr_en) m_err = 1;
      if (pipe_go) begin
        m_en = 1; m_addr = pipe_wr_addr; m_data = pipe_wr_data;
      end else if (had) begin
        m_en = 1; m_addr = qa.pop_front(); m_data = qd.pop_front();
      end else if (byp) begin
        m_en = 1; m_addr = md_wr_addr; m_data = md_wr_data;
      end else begin
        m_en = 0;
      end
      if (m_stall) begin
        m_stall = 0; m_blocked_run = 0;
      end else if (had && pipe_go) begin
        m_blocked_run++;
        if (m_blocked_run == MAX_WAIT) begin
          m_stall = 1; m_blocked_run = 0;
        end
      end else begin
        m_blocked_run = 0;
      end
      if (accept && md_wr_addr != 0 && !byp) begin
        qa.push_back(md_wr_addr); qd.push_back(md_wr_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model rf_wr_en", rf_wr_en, m_en);
      check("model rf_wr_addr", rf_wr_addr, m_addr);
      check("model rf_wr_data", rf_wr_data, m_data);
      check("model stall_req", stall_req, m_stall);
      check("model proto_err", proto_err, m_err);
      check("model md_ready", md_ready, qa.size() != DEPTH);
      check("model md_pending", md_pending, qa.size() != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit pe, input int pa, input int pd, input bit mv, input int ma, input int md);
    pipe_wr_en = pe; pipe_wr_addr = AW'(pa); pipe_wr_data = DW'(pd);
    md_valid = mv; md_wr_addr = AW'(ma); md_wr_data = DW'(md);
  endtask

  initial begin
    repeat (2) tick();
    check("reset rf_wr_en", rf_wr_en, 0);
    check("reset md_ready", md_ready, 1);
    check("reset stall_req", stall_req, 0);
    check("reset proto_err", proto_err, 0);
    check("reset md_pending", md_pending, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Pipe write r5
    drive(1, 5, 'h1234, 0, 0, 0);
    tick();
    check("pipe r5 en", rf_wr_en, 1);
    check("pipe r5 addr", rf_wr_addr, 5);
    check("pipe r5 data", rf_wr_data, 'h1234);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("idle en", rf_wr_en, 0);
    check("idle addr hold", rf_wr_addr, 5);

    // md r7 with pipe idle
    drive(0, 0, 0, 1, 7, 'hAA);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    if (BYP) begin
      check("md bypass en", rf_wr_en, 1);
      check("md bypass addr", rf_wr_addr, 7);
      check("md bypass data", rf_wr_data, 'hAA);
    end else begin
      check("md queued en", rf_wr_en, 0);
      check("md queued pending", md_pending, 1);
      tick();
      check("md drain en", rf_wr_en, 1);
      check("md drain addr", rf_wr_addr, 7);
      check("md drain data", rf_wr_data, 'hAA);
    end
    tick();

    // Same-cycle pipe r3 and md r4
    drive(1, 3, 1, 1, 4, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("race pipe addr", rf_wr_addr, 3);
    check("race pipe data", rf_wr_data, 1);
    tick();
    check("race md en", rf_wr_en, 1);
    check("race md addr", rf_wr_addr, 4);
    check("race md data", rf_wr_data, 2);
    tick();

    // r0 writes from both sources are dropped
    drive(1, 0, 'h55, 1, 0, 'h66);
    check("r0 md_ready", md_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("r0 rf_wr_en", rf_wr_en, 0);
    check("r0 md_pending", md_pending, 0);
    tick();

    // Pipe busy, four md pushes, starvation bubble, ordered drain
    for (int i = 0; i < 9; i++) begin
      drive(1, 1 + i, i, i < 4, 10 + i, 'hA0 + i);
      tick();
      if (i == 3) check("full md_ready", md_ready, 0);
      if (i == 7) check("starve not yet", stall_req, 0);
      if (i == 8) check("starve stall_req", stall_req, 1);
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain addr", rf_wr_addr, 10 + i);
      check("drain data", rf_wr_data, 'hA0 + i);
    end
    check("drain stall cleared", stall_req, 0);
    check("drain empty", md_pending, 0);
    tick();

    // Protocol error: pipeline ignores the bubble
    for (int i = 0; i < 10; i++) begin
      drive(1, 1 + i, 'h90 + i, i == 0, 20, 'hBEEF);
      tick();
    end
    check("proto wins addr", rf_wr_addr, 10);
    check("proto wins data", rf_wr_data, 'h99);
    check("proto_err set", proto_err, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("proto late drain", rf_wr_addr, 20);
    check("proto_err sticky", proto_err, 1);

    // Async reset with three queued entries
    for (int i = 0; i < 3; i++) begin
      drive(1, 2, 'h77, 1, 11 + i, i);
      tick();
    end
    check("pre-reset pending", md_pending, 1);
    check("pre-reset en", rf_wr_en, 1);
    rst = 1'b1;
    #1;
    check("async rst en", rf_wr_en, 0);
    check("async rst pending", md_pending, 0);
    check("async rst proto_err", proto_err, 0);
    check("async rst md_ready", md_ready, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post-reset en", rf_wr_en, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
